// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : imm_extend_pipe
//  Purpose  : Registered RV immediate generator with valid/ready handshake.
//             Extracts I/S/B/J/U/Z/SH immediates, extends to XLEN and holds
//             the result until the consumer takes it.
//  Revision : 1.0 - initial release
// ============================================================================
module imm_extend_pipe #(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 0,
  parameter int TAG_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] c_fmt_i   = 3'd0;
  localparam logic [2:0] c_fmt_s   = 3'd1;
  localparam logic [2:0] c_fmt_b   = 3'd2;
  localparam logic [2:0] c_fmt_j   = 3'd3;
  localparam logic [2:0] c_fmt_u   = 3'd4;
  localparam logic [2:0] c_fmt_z   = 3'd5;
  localparam logic [2:0] c_fmt_sh  = 3'd6;
  localparam logic [2:0] c_fmt_bad = 3'd7;

  // Only RV32 and RV64 result widths are meaningful.
  generate
    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
      $error("imm_extend_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  logic [2:0]      w_fmt;
  logic [31:0]     w_imm32;
  logic            w_sx;
  logic [XLEN-1:0] w_imm;
  logic            w_err;
  logic            w_accept;

  logic            r_valid;
  logic [XLEN-1:0] r_imm;
  logic [2:0]      r_type;
  logic            r_err;
  logic [TAG_W-1:0] r_tag;

  // Format source: opcode decode or the controller's select.
  generate
    if (AUTO_DECODE != 0) begin : g_auto
      // Map the major opcode (and funct3 where needed) to an immediate format.
      always_comb begin
        w_fmt = c_fmt_bad;
        case (in_instr[6:0])
          7'b0000011, 7'b1100111: w_fmt = c_fmt_i;
          // funct3 001/101 are the shift-immediate forms
          7'b0010011:             w_fmt = (in_instr[13:12] == 2'b01) ? c_fmt_sh : c_fmt_i;
          7'b0100011:             w_fmt = c_fmt_s;
          7'b1100011:             w_fmt = c_fmt_b;
          7'b1101111:             w_fmt = c_fmt_j;
          7'b0110111, 7'b0010111: w_fmt = c_fmt_u;
          7'b1110011:             w_fmt = in_instr[14] ? c_fmt_z : c_fmt_i;
          default:                w_fmt = c_fmt_bad;
        endcase
      end
      logic w_unused_src;
      assign w_unused_src = ^in_imm_src;
    end else begin : g_manual
      assign w_fmt = in_imm_src;
      logic w_unused_opcode;
      assign w_unused_opcode = ^in_instr[6:0];
    end
  endgenerate

  // Assemble the 32-bit immediate; the upper XLEN bits are added below.
  always_comb begin
    w_imm32 = 32'd0;
    case (w_fmt)
      c_fmt_i:  w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      c_fmt_s:  w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      c_fmt_b:  w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
      c_fmt_j:  w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
      c_fmt_u:  w_imm32 = {in_instr[31:12], 12'd0};
      c_fmt_z:  w_imm32 = {27'd0, in_instr[19:15]};
      // RV64 shift amounts carry one more bit
      c_fmt_sh: w_imm32 = (XLEN == 64) ? {26'd0, in_instr[25:20]}
                                       : {27'd0, in_instr[24:20]};
      default:  w_imm32 = 32'd0;
    endcase
  end

  // Z and SH are unsigned; everything else extends from bit 31.
  assign w_sx  = (w_fmt <= c_fmt_u) && w_imm32[31];
  assign w_err = (w_fmt == c_fmt_bad);

  generate
    if (XLEN == 64) begin : g_x64
      assign w_imm = {{32{w_sx}}, w_imm32};
    end else begin : g_x32
      assign w_imm = w_imm32;
    end
  endgenerate

  assign in_ready = !flush && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Output holding register: load on accept, clear valid on drain or flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_imm   <= '0;
      r_type  <= 3'd0;
      r_err   <= 1'b0;
      r_tag   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_imm   <= w_imm;
      r_type  <= w_fmt;
      r_err   <= w_err;
      r_tag   <= in_tag;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_imm   = r_imm;
  assign out_type  = r_type;
  assign out_err   = r_err;
  assign out_tag   = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_extend_pipe
//  Purpose  : Scoreboard bench for imm_extend_pipe (manual RV32, auto RV32,
//             auto RV64 instances).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        err;
    logic [31:0] tag;
  } exp_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [2:0]  src;
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t q0[$], q1[$], q2[$];

  // DUT 0: manual select, RV32
  logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0, out_err0;
  logic [31:0] in_instr0, in_tag0, out_imm0, out_tag0;
  logic [2:0]  in_src0, out_type0;
  // DUT 1: auto decode, RV32
  logic        flush1, in_valid1, in_ready1, out_valid1, out_ready1, out_err1;
  logic [31:0] in_instr1, in_tag1, out_imm1, out_tag1;
  logic [2:0]  in_src1, out_type1;
  // DUT 2: auto decode, RV64
  logic        flush2, in_valid2, in_ready2, out_valid2, out_ready2, out_err2;
  logic [31:0] in_instr2, in_tag2, out_tag2;
  logic [63:0] out_imm2;
  logic [2:0]  in_src2, out_type2;

  imm_extend_pipe #(.XLEN(32), .AUTO_DECODE(0), .TAG_W(32)) u_d0 (
    .clk(clk), .rst_n(rst_n), .flush(flush0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_instr(in_instr0), .in_imm_src(in_src0), .in_tag(in_tag0), .out_valid(out_valid0),
    .out_ready(out_ready0), .out_imm(out_imm0), .out_type(out_type0), .out_err(out_err0),
    .out_tag(out_tag0));

  imm_extend_pipe #(.XLEN(32), .AUTO_DECODE(1), .TAG_W(32)) u_d1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_instr(in_instr1), .in_imm_src(in_src1), .in_tag(in_tag1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_imm(out_imm1), .out_type(out_type1), .out_err(out_err1),
    .out_tag(out_tag1));

  imm_extend_pipe #(.XLEN(64), .AUTO_DECODE(1), .TAG_W(32)) u_d2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_instr(in_instr2), .in_imm_src(in_src2), .in_tag(in_tag2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_imm(out_imm2), .out_type(out_type2), .out_err(out_err2),
    .out_tag(out_tag2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic cmp(input string who, input exp_t e, input logic [63:0] imm,
                     input logic [2:0] typ, input logic err, input logic [31:0] tag);
    chk({who, "_imm"}, imm, e.imm);
    chk({who, "_type"}, {61'd0, typ}, {61'd0, e.typ});
    chk({who, "_err"}, {63'd0, err}, {63'd0, e.err});
    chk({who, "_tag"}, {32'd0, tag}, {32'd0, e.tag});
  endtask

  task automatic unexpected(input string who);
    checks++;
    errors++;
    $display("FAIL %s_unexpected: output presented with empty scoreboard", who);
  endtask

  // Monitors: a result is checked when it is consumed or flushed away.
  exp_t e0, e1, e2;
  always @(negedge clk) begin
    if (out_valid0 === 1'b1 && (out_ready0 || flush0)) begin
      if (q0.size() == 0) unexpected("d0");
      else begin
        e0 = q0.pop_front();
        cmp("d0", e0, {32'd0, out_imm0}, out_type0, out_err0, out_tag0);
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid1 === 1'b1 && (out_ready1 || flush1)) begin
      if (q1.size() == 0) unexpected("d1");
      else begin
        e1 = q1.pop_front();
        cmp("d1", e1, {32'd0, out_imm1}, out_type1, out_err1, out_tag1);
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid2 === 1'b1 && (out_ready2 || flush2)) begin
      if (q2.size() == 0) unexpected("d2");
      else begin
        e2 = q2.pop_front();
        cmp("d2", e2, out_imm2, out_type2, out_err2, out_tag2);
      end
    end
  end

  task automatic drive(input int d, input logic v, input logic [31:0] ins,
                       input logic [2:0] src, input logic [31:0] tag);
    case (d)
      0: begin in_valid0 = v; in_instr0 = ins; in_src0 = src; in_tag0 = tag; end
      1: begin in_valid1 = v; in_instr1 = ins; in_src1 = src; in_tag1 = tag; end
      default: begin in_valid2 = v; in_instr2 = ins; in_src2 = src; in_tag2 = tag; end
    endcase
  endtask

  function automatic logic rdy(input int d);
    case (d)
      0: return in_ready0;
      1: return in_ready1;
      default: return in_ready2;
    endcase
  endfunction

  // Present one instruction, wait (bounded) for acceptance, record expectation.
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int d, input vec_t v, input logic [31:0] tag);
    int   n;
    logic acc;
    exp_t e;
    n = 0;
    drive(d, 1'b1, v.ins, v.src, tag);
    do begin
      @(negedge clk);
      acc = rdy(d);
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 20);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: dut %0d never ready, got 0, expected 1", d);
    end else begin
      e = '{imm: v.imm, typ: v.typ, err: v.err, tag: tag};
      case (d)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
    drive(d, 1'b0, 32'd0, 3'd0, 32'd0);
  endtask

  vec_t tab0[8];
  vec_t tab1[14];
  vec_t tab2[7];
  vec_t va, vb;

  initial begin
    // Manual RV32: one vector per format select
    tab0[0] = '{32'hFFF00093, 3'd0, 64'hFFFFFFFF, 3'd0, 1'b0};
    tab0[1] = '{32'hFE20AE23, 3'd1, 64'hFFFFFFFC, 3'd1, 1'b0};
    tab0[2] = '{32'hFE000EE3, 3'd2, 64'hFFFFFFFC, 3'd2, 1'b0};
    tab0[3] = '{32'h008000EF, 3'd3, 64'h00000008, 3'd3, 1'b0};
    tab0[4] = '{32'h12345037, 3'd4, 64'h12345000, 3'd4, 1'b0};
    tab0[5] = '{32'h3002D073, 3'd5, 64'h00000005, 3'd5, 1'b0};
    tab0[6] = '{32'h00309093, 3'd6, 64'h00000003, 3'd6, 1'b0};
    tab0[7] = '{32'h12345678, 3'd7, 64'h00000000, 3'd7, 1'b1};
    // Auto RV32 (src field deliberately wrong to show it is ignored)
    tab1[0]  = '{32'h00309093, 3'd0, 64'h00000003, 3'd6, 1'b0};
    tab1[1]  = '{32'h3002D073, 3'd0, 64'h00000005, 3'd5, 1'b0};
    tab1[2]  = '{32'h0000007F, 3'd0, 64'h00000000, 3'd7, 1'b1};
    tab1[3]  = '{32'hFFF00093, 3'd7, 64'hFFFFFFFF, 3'd0, 1'b0};
    tab1[4]  = '{32'h40105013, 3'd0, 64'h00000001, 3'd6, 1'b0};
    tab1[5]  = '{32'hFE20AE23, 3'd0, 64'hFFFFFFFC, 3'd1, 1'b0};
    tab1[6]  = '{32'hFE000EE3, 3'd0, 64'hFFFFFFFC, 3'd2, 1'b0};
    tab1[7]  = '{32'h008000EF, 3'd0, 64'h00000008, 3'd3, 1'b0};
    tab1[8]  = '{32'h800000B7, 3'd0, 64'h80000000, 3'd4, 1'b0};
    tab1[9]  = '{32'h30029073, 3'd0, 64'h00000300, 3'd0, 1'b0};
    tab1[10] = '{32'h00812083, 3'd0, 64'h00000008, 3'd0, 1'b0};
    tab1[11] = '{32'h00008067, 3'd0, 64'h00000000, 3'd0, 1'b0};
    tab1[12] = '{32'h00001097, 3'd0, 64'h00001000, 3'd4, 1'b0};
    tab1[13] = '{32'h42305013, 3'd0, 64'h00000003, 3'd6, 1'b0};
    // Auto RV64
    tab2[0] = '{32'h800000B7, 3'd0, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
    tab2[1] = '{32'h02309093, 3'd0, 64'h0000000000000023, 3'd6, 1'b0};
    tab2[2] = '{32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0};
    tab2[3] = '{32'h3002D073, 3'd0, 64'h0000000000000005, 3'd5, 1'b0};
    tab2[4] = '{32'h0000007F, 3'd0, 64'h0000000000000000, 3'd7, 1'b1};
    tab2[5] = '{32'hFE000EE3, 3'd0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0};
    tab2[6] = '{32'h42305013, 3'd0, 64'h0000000000000023, 3'd6, 1'b0};

    rst_n = 1'b0;
    flush0 = 1'b0; flush1 = 1'b0; flush2 = 1'b0;
    out_ready0 = 1'b1; out_ready1 = 1'b1; out_ready2 = 1'b1;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 32'd0, 3'd0, 32'd0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {63'd0, out_valid0}, 64'd0);
    chk("rst_imm", {32'd0, out_imm0}, 64'd0);
    chk("rst_type", {61'd0, out_type0}, 64'd0);
    chk("rst_err", {63'd0, out_err0}, 64'd0);
    chk("rst_tag", {32'd0, out_tag0}, 64'd0);
    chk("rst_imm64", out_imm2, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Every format, manual select, with idle gaps
    for (int i = 0; i < 8; i++) begin
      send(0, tab0[i], 32'h100 + i);
      @(posedge clk);
      #1;
    end

    // Opcode decode, both widths
    for (int i = 0; i < 14; i++) send(1, tab1[i], 32'h200 + i);
    for (int i = 0; i < 7; i++) send(2, tab2[i], 32'h300 + i);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back stream: eight consecutive valid cycles
    fork
      begin
        for (int i = 0; i < 8; i++) send(0, tab0[i], 32'h1000 + 4 * i);
      end
      begin
        int w;
        int n;
        w = 0;
        n = 0;
        do begin
          @(negedge clk);
          w++;
        end while (out_valid0 !== 1'b1 && w < 30);
        while (out_valid0 === 1'b1 && n < 20) begin
          n++;
          @(negedge clk);
        end
        chk("b2b_streak", n, 64'd8);
      end
    join
    @(posedge clk);
    #1;

    // Backpressure: A held while B waits
    va = tab0[0];
    vb = tab0[6];
    out_ready0 = 1'b0;
    send(0, va, 32'hAAAA0000);
    drive(0, 1'b1, vb.ins, vb.src, 32'hBBBB0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {63'd0, in_ready0}, 64'd0);
      chk("bp_valid", {63'd0, out_valid0}, 64'd1);
      chk("bp_imm", {32'd0, out_imm0}, 64'hFFFFFFFF);
      chk("bp_tag", {32'd0, out_tag0}, 64'hAAAA0000);
      @(posedge clk);
      #1;
    end
    out_ready0 = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {63'd0, in_ready0}, 64'd1);
    @(posedge clk);
    #1;
    q0.push_back('{imm: vb.imm, typ: vb.typ, err: vb.err, tag: 32'hBBBB0000});
    drive(0, 1'b0, 32'd0, 3'd0, 32'd0);
    @(negedge clk);
    chk("bp_b_no_gap", {63'd0, out_valid0}, 64'd1);
    @(posedge clk);
    #1;

    // Flush with A held and a new input offered
    out_ready0 = 1'b0;
    send(0, va, 32'hCCCC0000);
    drive(0, 1'b1, vb.ins, vb.src, 32'hDDDD0000);
    flush0 = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {63'd0, in_ready0}, 64'd0);
    @(posedge clk);
    #1;
    flush0 = 1'b0;
    drive(0, 1'b0, 32'd0, 3'd0, 32'd0);
    @(negedge clk);
    chk("flush_valid", {63'd0, out_valid0}, 64'd0);
    @(posedge clk);
    #1;

    // Reset while a result is held: the pending result is discarded
    send(0, va, 32'hEEEE0000);
    @(negedge clk);
    chk("pre_rst_valid", {63'd0, out_valid0}, 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q0.delete();
    out_ready0 = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", {63'd0, out_valid0}, 64'd0);
    chk("mid_rst_imm", {32'd0, out_imm0}, 64'd0);
    chk("mid_rst_type", {61'd0, out_type0}, 64'd0);
    chk("mid_rst_err", {63'd0, out_err0}, 64'd0);
    chk("mid_rst_tag", {32'd0, out_tag0}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready0}, 64'd1);

    // Drain: every expected result must have been seen
    for (int i = 0; i < 20 && (q0.size() + q1.size() + q2.size()) != 0; i++) @(posedge clk);
    #1;
    chk("q0_empty", q0.size(), 64'd0);
    chk("q1_empty", q1.size(), 64'd0);
    chk("q2_empty", q2.size(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Registered, parametrised immediate generator for the multi-cycle RV core. It accepts an instruction word over a valid/ready handshake and extracts its immediate, including the Z (CSR uimm) and shift-amount formats. Output is sign- or zero-extended to XLEN. The immediate is held stable in an output register until the consumer FSM takes it. Source format comes either from the controller's immSrc or from internal opcode decode.

Parameters:
XLEN, 32, result width; legal values 32 or 64 only.
AUTO_DECODE, 0, 1 = derive the format from the opcode and ignore imm_src; 0 = use imm_src.
TAG_W, 32, width of the sideband tag (typically the PC), passed through unchanged.

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
flush  in  1  drop held result; block new input this cycle
in_valid  in  1  instruction presented
in_ready  out  1  block can accept
in_instr  in  32  full instruction word
in_imm_src  in  3  format select (unused when AUTO_DECODE=1)
in_tag  in  TAG_W  sideband, e.g. PC
out_valid  out  1  result held
out_ready  in  1  consumer takes result
out_imm  out  XLEN  extended immediate
out_type  out  3  format actually applied
out_err  out  1  illegal format/opcode
out_tag  out  TAG_W  registered in_tag

Behaviour:
- Reset is sampled on rising clk while rst_n=0. Reset values: out_valid=0, out_imm=0, out_type=0, out_err=0, out_tag=0. This holds mid-transfer too; any pending result is discarded.
- Ready rule: in_ready = !flush && (!out_valid || out_ready). This is combinational.
- Accept: in_valid && in_ready at a clock edge. Next cycle out_valid=1 with all outputs registered. Latency is 1 cycle, and full throughput holds under continuous out_ready=1.
- Simultaneous drain and accept, with out_valid && out_ready && in_valid: the new result replaces the old in the same edge, with no bubble.
- Hold: while out_valid && !out_ready, out_imm, out_type, out_err and out_tag do not change.
- Drain with no accept: out_valid goes to 0. Data regs keep their old values.
- flush=1: out_valid goes to 0 next edge and no input is accepted that cycle. Reset takes priority over flush.
- Formats (sx = sign-extend to XLEN from bit 31 of instr):
  - 000 I: sx(instr[31:20])
  - 001 S: sx(instr[31:25], instr[11:7])
  - 010 B: sx(instr[31], instr[7], instr[30:25], instr[11:8], 0)
  - 011 J: sx(instr[31], instr[19:12], instr[20], instr[30:21], 0)
  - 100 U: sx(instr[31:12], 12'b0). On XLEN=64 the result is sign-extended from bit 31.
  - 101 Z: zero-extend(instr[19:15])
  - 110 SH: zero-extend(instr[24:20]) when XLEN=32; zero-extend(instr[25:20]) when XLEN=64
  - 111: out_imm=0, out_err=1
- All other formats give out_err=0.
- AUTO_DECODE opcode map (instr[6:0]):
  - 0000011, 1100111: I
  - 0010011: SH if funct3 (instr[14:12]) is 001 or 101, else I
  - 0100011: S
  - 1100011: B
  - 1101111: J
  - 0110111, 0010111: U
  - 1110011: Z if instr[14]=1, else I
  - any other opcode: type 111, err=1
- out_type always reports the format applied.
- Decode is combinational on the input side only; nothing combinational drives the outputs.
- Out-of-range XLEN is a compile-time error via an elaboration assertion.

Test Plan:
- XLEN=32, manual mode, out_ready=1:
  - 0xFFF00093 with src 000 gives out_imm 0xFFFFFFFF one cycle later, type 000, err 0.
  - 0xFE20AE23 with src 001 gives out_imm 0xFFFFFFFC.
  - 0xFE000EE3 with src 010 gives out_imm 0xFFFFFFFC.
- AUTO_DECODE=1, XLEN=32:
  - 0x00309093 (slli) gives imm 3, type 110.
  - 0x3002D073 (csrrwi) gives imm 5, type 101.
  - opcode 0x7F gives imm 0, err 1, type 111.
- XLEN=64, auto:
  - 0x800000B7 (lui) gives out_imm 0xFFFFFFFF80000000.
  - slli with shamt 0x23 gives imm 0x23.
- Backpressure: accept A=0xFFF00093, hold out_ready=0 for 3 cycles while in_valid=1 with B=0x00309093.
  - Required: in_ready=0, and out_imm stays 0xFFFFFFFF with out_tag constant.
  - Raise out_ready: B appears the following cycle with no gap and no loss.
- Flush, then reset:
  - With A held, pulse flush while in_valid=1: next cycle out_valid=0 and the input is not taken.
  - Later, drop rst_n for one edge with a result held: all outputs read 0 and in_ready=1 after release.
- Back-to-back: stream 8 instructions with in_valid=out_ready=1. Required: 8 consecutive out_valid cycles, in order, tags matching.
